// File: rtl/spi_ddio_lane_serializer.sv
// SPI transmit serializer for DDIO output cells: 1/2/4 lanes, SDR or DTR, with chip-select framing.
// Words arrive over valid/ready and are emitted MSB first, one beat (one SCLK period) per clk.
module spi_ddio_lane_serializer #(
  parameter int LANES    = 4,
  parameter int DTR      = 0,
  parameter int DATA_W   = 8,
  parameter int CPOL     = 0,
  parameter int CS_SETUP = 1,
  parameter int CS_HOLD  = 1,
  parameter int CS_IDLE  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_last,
  output logic                 cs_n,
  output logic [1:0]           sclk_ddr,
  output logic [2*LANES-1:0]   dout_ddr,
  output logic                 oe,
  output logic                 busy,
  output logic                 underrun,
  output logic [2:0]           dbg_state
);

  localparam int BPC   = LANES * ((DTR != 0) ? 2 : 1);
  localparam int BEATS = DATA_W / BPC;
  localparam int CW    = $clog2(BEATS + 1);
  localparam logic [CW-1:0] BEATS_C    = CW'(BEATS);
  localparam logic [CW-1:0] BEATS_M1   = CW'(BEATS - 1);
  localparam logic          CP         = (CPOL != 0);
  localparam logic [1:0]    SCLK_IDLE  = {CP, CP};
  localparam logic [1:0]    SCLK_BEAT  = {~CP, CP};
  localparam logic [7:0]    SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0]    HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [7:0]    GAP_LAST   = 8'((CS_IDLE >= 2) ? CS_IDLE - 2 : 0);
  localparam logic          ONE_BEAT   = (BEATS == 1);

  // Handshake: a word transfers on any rising clk edge where s_valid and s_ready are both high;
  // s_ready is registered, and s_data/s_last are ignored on every other edge.
  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, STALL, HOLD, GAP} state_t;
  state_t state;

  logic [DATA_W-1:0]  shreg;
  logic               last_q;
  logic [CW-1:0]      beat_cnt;
  logic [7:0]         cnt;
  logic               accept;
  logic [2*LANES-1:0] bits_sh, bits_in;
  logic [DATA_W-1:0]  next_sh, next_in;

  // Top BPC bits of a word mapped to {low-half lanes, high-half lanes}; lane LANES-1 carries the MSB.
  function automatic logic [2*LANES-1:0] lane_bits(input logic [DATA_W-1:0] w);
    logic [BPC-1:0] top;
    top = w[DATA_W-1 -: BPC];
    if (DTR != 0) lane_bits = {top[LANES-1:0], top[BPC-1 -: LANES]};
    else          lane_bits = {top[LANES-1:0], top[LANES-1:0]};
  endfunction

  assign accept    = s_valid & s_ready;
  assign bits_sh   = lane_bits(shreg);
  assign bits_in   = lane_bits(s_data);
  assign next_sh   = shreg << BPC;
  assign next_in   = s_data << BPC;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cs_n     <= 1'b1;
      sclk_ddr <= SCLK_IDLE;
      dout_ddr <= '0;
      oe       <= 1'b0;
      busy     <= 1'b0;
      underrun <= 1'b0;
      s_ready  <= 1'b0;
      shreg    <= '0;
      last_q   <= 1'b0;
      beat_cnt <= '0;
      cnt      <= '0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (accept) begin
            shreg   <= s_data;
            last_q  <= s_last;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            s_ready <= 1'b0;
            cnt     <= '0;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state    <= SHIFT;
            sclk_ddr <= SCLK_BEAT;
            oe       <= 1'b1;
            dout_ddr <= bits_sh;
            shreg    <= next_sh;
            beat_cnt <= CW'(1);
            s_ready  <= ONE_BEAT & ~last_q;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SHIFT: begin
          if (beat_cnt != BEATS_C) begin
            dout_ddr <= bits_sh;
            shreg    <= next_sh;
            beat_cnt <= beat_cnt + CW'(1);
            s_ready  <= (beat_cnt == BEATS_M1) & ~last_q;
          end else if (accept) begin
            // Next word continues straight from the bus: no SCLK gap between words.
            dout_ddr <= bits_in;
            shreg    <= next_in;
            last_q   <= s_last;
            beat_cnt <= CW'(1);
            s_ready  <= ONE_BEAT & ~s_last;
          end else begin
            sclk_ddr <= SCLK_IDLE;
            oe       <= 1'b0;
            if (!last_q) begin
              state    <= STALL;
              underrun <= 1'b1;
              s_ready  <= 1'b1;
            end else begin
              state   <= HOLD;
              s_ready <= 1'b0;
              cnt     <= '0;
            end
          end
        end
        STALL: begin
          if (accept) begin
            state    <= SHIFT;
            sclk_ddr <= SCLK_BEAT;
            oe       <= 1'b1;
            dout_ddr <= bits_in;
            shreg    <= next_in;
            last_q   <= s_last;
            beat_cnt <= CW'(1);
            s_ready  <= ONE_BEAT & ~s_last;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            cs_n <= 1'b1;
            cnt  <= '0;
            // The IDLE cycle itself counts toward the cs_n-high minimum.
            if (CS_IDLE <= 1) begin
              state   <= IDLE;
              busy    <= 1'b0;
              s_ready <= 1'b1;
            end else begin
              state <= GAP;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ddio_lane_serializer.sv
// Bench for spi_ddio_lane_serializer: three lane/rate configurations, beat scoreboard plus framing checks.
module tb_spi_ddio_lane_serializer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  // u1: LANES=1 SDR
  logic v1 = 0, l1 = 0, r1, cs1, oe1, bz1, un1;
  logic [7:0] d1 = 0;
  logic [1:0] sc1, do1;
  logic [2:0] st1;
  // u2: LANES=4 DTR
  logic v2 = 0, l2 = 0, r2, cs2, oe2, bz2, un2;
  logic [7:0] d2 = 0;
  logic [1:0] sc2;
  logic [7:0] do2;
  logic [2:0] st2;
  // u3: LANES=2 SDR
  logic v3 = 0, l3 = 0, r3, cs3, oe3, bz3, un3;
  logic [7:0] d3 = 0;
  logic [1:0] sc3;
  logic [3:0] do3;
  logic [2:0] st3;

  spi_ddio_lane_serializer #(.LANES(1), .DTR(0), .DATA_W(8)) u1 (
    .clk(clk), .reset(rst1), .s_valid(v1), .s_ready(r1), .s_data(d1), .s_last(l1),
    .cs_n(cs1), .sclk_ddr(sc1), .dout_ddr(do1), .oe(oe1), .busy(bz1), .underrun(un1), .dbg_state(st1));
  spi_ddio_lane_serializer #(.LANES(4), .DTR(1), .DATA_W(8)) u2 (
    .clk(clk), .reset(reset), .s_valid(v2), .s_ready(r2), .s_data(d2), .s_last(l2),
    .cs_n(cs2), .sclk_ddr(sc2), .dout_ddr(do2), .oe(oe2), .busy(bz2), .underrun(un2), .dbg_state(st2));
  spi_ddio_lane_serializer #(.LANES(2), .DTR(0), .DATA_W(8)) u3 (
    .clk(clk), .reset(reset), .s_valid(v3), .s_ready(r3), .s_data(d3), .s_last(l3),
    .cs_n(cs3), .sclk_ddr(sc3), .dout_ddr(do3), .oe(oe3), .busy(bz3), .underrun(un3), .dbg_state(st3));

  int vectors = 0;
  int miscompares = 0;

  logic [3:0] q1[$];
  logic [9:0] q2[$];
  logic [5:0] q3[$];
  int fl1[$], fl2[$], fl3[$];
  int run1 = 0, run2 = 0, run3 = 0;
  int un_cnt1 = 0;
  int oe_run3 = 0, last_run3 = 0;
  int rdy_q3[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected beats: one dout bit per beat, same value in both halves, SCLK {low,high}=10.
  task automatic push1(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) q1.push_back({2'b10, d[7-i], d[7-i]});
  endtask

  task automatic push3(input logic [7:0] d);
    logic [1:0] b;
    for (int i = 0; i < 4; i++) begin
      b = d[7-2*i -: 2];
      q3.push_back({2'b10, b, b});
    end
  endtask

  task automatic send1(input logic [7:0] d, input logic l);
    int t = 0;
    v1 = 1; d1 = d; l1 = l;
    while (!r1 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("u1_send_timeout", 1, 0);
    @(posedge clk); #1;
    v1 = 0;
  endtask

  task automatic send2(input logic [7:0] d, input logic l);
    int t = 0;
    v2 = 1; d2 = d; l2 = l;
    while (!r2 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("u2_send_timeout", 1, 0);
    @(posedge clk); #1;
    v2 = 0;
  endtask

  task automatic send3(input logic [7:0] d, input logic l);
    int t = 0;
    v3 = 1; d3 = d; l3 = l;
    while (!r3 && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("u3_send_timeout", 1, 0);
    @(posedge clk); #1;
    v3 = 0;
  endtask

  task automatic wait_idle(input int which);
    int t = 0;
    do begin
      @(negedge clk); t++;
    end while (((which == 1) ? bz1 : (which == 2) ? bz2 : bz3) && t < 300);
    if (t >= 300) check("wait_idle_timeout", which, 0);
  endtask

  // Monitors: pop an expected beat whenever oe is high; compare cs_n low run length per frame.
  always @(negedge clk) begin
    if (oe1) begin
      if (q1.size() == 0) check("u1_extra_beat", {sc1, do1}, 0);
      else check("u1_beat", {sc1, do1}, q1.pop_front());
    end else begin
      check("u1_sclk_idle", sc1, 2'b00);
    end
    if (un1) un_cnt1++;
    if (!cs1) run1++;
    else if (run1 > 0) begin
      if (fl1.size() == 0) check("u1_unexpected_frame", run1, 0);
      else check("u1_cs_low_cycles", run1, fl1.pop_front());
      run1 = 0;
    end
  end

  always @(negedge clk) begin
    if (oe2) begin
      if (q2.size() == 0) check("u2_extra_beat", {sc2, do2}, 0);
      else check("u2_beat", {sc2, do2}, q2.pop_front());
    end
    if (!cs2) run2++;
    else if (run2 > 0) begin
      if (fl2.size() == 0) check("u2_unexpected_frame", run2, 0);
      else check("u2_cs_low_cycles", run2, fl2.pop_front());
      run2 = 0;
    end
  end

  always @(negedge clk) begin
    if (oe3) begin
      if (q3.size() == 0) check("u3_extra_beat", {sc3, do3}, 0);
      else check("u3_beat", {sc3, do3}, q3.pop_front());
      oe_run3++;
      if (r3) rdy_q3.push_back(oe_run3);
    end else if (oe_run3 > 0) begin
      last_run3 = oe_run3;
      oe_run3 = 0;
    end
    if (!cs3) run3++;
    else if (run3 > 0) begin
      if (fl3.size() == 0) check("u3_unexpected_frame", run3, 0);
      else check("u3_cs_low_cycles", run3, fl3.pop_front());
      run3 = 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, gap, un0;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs1, 1);
    check("rst_sclk", sc1, 2'b00);
    check("rst_dout", do1, 0);
    check("rst_oe", oe1, 0);
    check("rst_busy", bz1, 0);
    check("rst_underrun", un1, 0);
    check("rst_s_ready", r1, 0);
    check("rst_state", st1, 0);
    check("rst_u2_dout", do2, 0);
    rst1 = 0; reset = 0;
    @(negedge clk);
    check("idle_s_ready", r1, 1);

    // 1: single 0xA5 frame on one lane, with latency check.
    push1(8'hA5, 8); fl1.push_back(10);
    send1(8'hA5, 1);
    @(negedge clk);
    check("lat_cs_low", cs1, 0);
    check("lat_no_beat_yet", oe1, 0);
    check("lat_busy", bz1, 1);
    @(negedge clk);
    check("lat_first_beat", oe1, 1);
    wait_idle(1);

    // 4: two-word frame with a 5-cycle stall between words.
    push1(8'h3C, 8); push1(8'hC3, 8); fl1.push_back(23);
    un0 = un_cnt1;
    send1(8'h3C, 0);
    t = 0;
    while (!un1 && t < 50) begin @(negedge clk); t++; end
    check("underrun_seen", un1, 1);
    check("stall_cs_low", cs1, 0);
    repeat (4) @(negedge clk);
    check("stall_ready", r1, 1);
    send1(8'hC3, 1);
    wait_idle(1);
    check("underrun_pulses", un_cnt1 - un0, 1);

    // 5: reset during beat 3 of 0xA5, then a clean frame.
    push1(8'hA5, 3); fl1.push_back(4);
    send1(8'hA5, 1);
    t = 0;
    while (!oe1 && t < 50) begin @(negedge clk); t++; end
    repeat (2) @(negedge clk);
    rst1 = 1;
    @(negedge clk);
    check("midrst_cs_n", cs1, 1);
    check("midrst_oe", oe1, 0);
    check("midrst_busy", bz1, 0);
    check("midrst_dout", do1, 0);
    check("midrst_s_ready", r1, 0);
    rst1 = 0;
    @(negedge clk);
    check("postrst_ready", r1, 1);
    push1(8'hA5, 8); fl1.push_back(10);
    send1(8'hA5, 1);
    wait_idle(1);

    // 6: back-to-back single-word frames, cs_n high gap of CS_IDLE cycles.
    push1(8'h0F, 8); push1(8'hF0, 8); fl1.push_back(10); fl1.push_back(10);
    gap = 0;
    fork
      begin
        send1(8'h0F, 1);
        send1(8'hF0, 1);
      end
      begin
        t = 0;
        while (cs1 && t < 50) begin @(negedge clk); t++; end
        while (!cs1 && t < 100) begin @(negedge clk); t++; end
        while (cs1 && t < 150) begin gap++; @(negedge clk); t++; end
      end
    join
    check("cs_gap_cycles", gap, 2);
    wait_idle(1);

    // 2: four lanes DTR, one beat per word.
    q2.push_back({2'b10, 8'hC3}); fl2.push_back(3);
    send2(8'h3C, 1);
    wait_idle(2);
    q2.push_back({2'b10, 8'h69}); fl2.push_back(3);
    send2(8'h96, 1);
    wait_idle(2);

    // 3: two lanes SDR, three words held valid -> 12 contiguous beats.
    push3(8'hFF); push3(8'h00); push3(8'h81); fl3.push_back(14);
    send3(8'hFF, 0);
    send3(8'h00, 0);
    send3(8'h81, 1);
    wait_idle(3);
    check("u3_contig_beats", last_run3, 12);
    check("u3_ready_pulses", rdy_q3.size(), 2);
    if (rdy_q3.size() == 2) begin
      check("u3_ready_beat_a", rdy_q3[0], 4);
      check("u3_ready_beat_b", rdy_q3[1], 8);
    end

    repeat (5) @(negedge clk);
    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    check("q3_drained", q3.size(), 0);
    check("frames_drained", fl1.size() + fl2.size() + fl3.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
